// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with load-use hazard detection; optional stall counter under STALL_CNT_EN
module if_id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCplus4In,
    input  logic [31:0] InstrIn,
    input  logic        ID_EXE_MemRead,
    input  logic [4:0]  ID_EXE_RtReg,
    input  logic        Flush,
    output logic [31:0] IF_ID_PCplus4,
    output logic [31:0] IF_ID_Instr,
    output logic [4:0]  IF_ID_Rs,
    output logic [4:0]  IF_ID_Rt,
    output logic [4:0]  IF_ID_Rd,
    output logic [4:0]  IF_ID_Shamt,
    output logic [5:0]  IF_ID_Func,
    output logic [4:0]  IF_ID_fmt,
    output logic [4:0]  IF_ID_Ft,
    output logic [4:0]  IF_ID_Fd,
    output logic        IF_ID_Valid,
`ifdef STALL_CNT_EN
    output logic [15:0] StallCount,
`endif
    output logic        PCWrite,
    output logic        Bubble
);

    logic hazard;

    // Field decode is a pure slice of the latched word, so a flushed slot reads all zero
    assign IF_ID_Rs    = IF_ID_Instr[25:21];
    assign IF_ID_Rt    = IF_ID_Instr[20:16];
    assign IF_ID_Rd    = IF_ID_Instr[15:11];
    assign IF_ID_Shamt = IF_ID_Instr[10:6];
    assign IF_ID_Func  = IF_ID_Instr[5:0];
    assign IF_ID_fmt   = IF_ID_Instr[25:21];
    assign IF_ID_Ft    = IF_ID_Instr[20:16];
    assign IF_ID_Fd    = IF_ID_Instr[10:6];

    // Load-use hazard: a load in ID/EXE writes a register the instruction in IF/ID reads
    always_comb begin
        hazard = IF_ID_Valid && ID_EXE_MemRead && (ID_EXE_RtReg != 5'd0) &&
                 ((ID_EXE_RtReg == IF_ID_Rs) || (ID_EXE_RtReg == IF_ID_Rt));
    end

    // A flush always lets fetch redirect and squashes the decode slot
    assign PCWrite = !hazard || Flush;
    assign Bubble  = hazard || Flush;

    // Pipeline register: flush beats stall beats normal load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IF_ID_Instr   <= 32'd0;
            IF_ID_PCplus4 <= 32'd0;
            IF_ID_Valid   <= 1'b0;
        end else if (Flush) begin
            IF_ID_Instr   <= 32'd0;
            IF_ID_PCplus4 <= 32'd0;
            IF_ID_Valid   <= 1'b0;
        end else if (!hazard) begin
            IF_ID_Instr   <= InstrIn;
            IF_ID_PCplus4 <= PCplus4In;
            IF_ID_Valid   <= 1'b1;
        end
    end

`ifdef STALL_CNT_EN
    // Saturating count of real stall cycles; a flushed hazard is not a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= 16'd0;
        end else if (hazard && !Flush && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end
`endif

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 PCplus4In  in  32  fetch-stage PC+4.
REQ-004 InstrIn  in  32  fetched instruction word.
REQ-005 ID_EXE_MemRead  in  1  load currently in ID/EXE.
REQ-006 ID_EXE_RtReg  in  5  destination of that load.
REQ-007 Flush  in  1  taken branch/jump redirect from a later stage.
REQ-008 IF_ID_PCplus4  out  32  latched PC+4.
REQ-009 IF_ID_Instr  out  32  latched instruction.
REQ-010 IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, IF_ID_Shamt  out  5 each  = Instr[25:21], [20:16], [15:11], [10:6].
REQ-011 IF_ID_Func  out  6  = Instr[5:0].
REQ-012 IF_ID_fmt, IF_ID_Ft, IF_ID_Fd  out  5 each  = Instr[25:21], [20:16], [10:6].
REQ-013 IF_ID_Valid  out  1  latched slot holds a real instruction.
REQ-014 PCWrite  out  1  fetch PC may advance.
REQ-015 Bubble  out  1  ID/EXE must capture all-zero control this cycle.
REQ-016 StallCount  out  16  present only with STALL_CNT_EN.

Function
REQ-017 Hazard = IF_ID_Valid & ID_EXE_MemRead & (ID_EXE_RtReg != 0) & (ID_EXE_RtReg == IF_ID_Rs | ID_EXE_RtReg == IF_ID_Rt); combinational, no added latency.
REQ-018 PCWrite SHALL be ~Hazard | Flush; Bubble SHALL be Hazard | Flush.
REQ-019 Each rising edge, priority order: Flush > Hazard > load.
REQ-020 Flush: IF_ID_Instr <= 0, IF_ID_PCplus4 <= 0, IF_ID_Valid <= 0, regardless of Hazard.
REQ-021 Hazard without Flush: all IF/ID registers hold current value (stall).
REQ-022 Otherwise: IF_ID_Instr <= InstrIn, IF_ID_PCplus4 <= PCplus4In, IF_ID_Valid <= 1; one-cycle latency input to output.
REQ-023 Field outputs SHALL be pure slices of IF_ID_Instr, so all fields read zero while invalid.
REQ-024 A load-use stall SHALL last exactly one cycle: after one stall edge the load leaves ID/EXE (ID_EXE_MemRead falls because Bubble was inserted), and Hazard deasserts.
REQ-025 Back-to-back hazards (new load to same register in ID/EXE again) SHALL each stall one further cycle; no internal limit.
REQ-026 Hazard SHALL never assert when IF_ID_Valid = 0 or ID_EXE_RtReg = 0.

Reset
REQ-027 While rst_n = 0: IF_ID_Instr = 0, IF_ID_PCplus4 = 0, IF_ID_Valid = 0, StallCount = 0; PCWrite = 1, Bubble = 0 (Flush low).
REQ-028 Reset assertion mid-stall SHALL clear state immediately; first edge after release SHALL load normally.

Configuration
REQ-029 Macro STALL_CNT_EN: when defined, StallCount increments by 1 on every edge where Hazard & ~Flush, saturating at 16'hFFFF, cleared only by reset.
REQ-030 Without STALL_CNT_EN: StallCount port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset release, InstrIn=32'h012A4020 (add $8,$9,$10), PCplus4In=32'h4 -> next edge: Valid=1, Rs=9, Rt=10, Rd=8, Func=6'h20, PCplus4=4.
REQ-032 IF/ID holds Rs=9; ID_EXE_MemRead=1, ID_EXE_RtReg=9 -> PCWrite=0, Bubble=1, IF/ID unchanged next edge; MemRead drops -> loads new InstrIn following edge; StallCount=1 (with macro).
REQ-033 Same as 032 but ID_EXE_RtReg=0 -> no stall, PCWrite=1, Bubble=0.
REQ-034 Hazard and Flush both high -> next edge Instr=0, Valid=0, PCWrite=1, StallCount unchanged.
REQ-035 Force Hazard for 70000 consecutive cycles (with macro) -> StallCount saturates at 16'hFFFF.
REQ-036 rst_n pulsed low mid-stall between edges -> outputs zero immediately, Valid=0, StallCount=0.
